zion_riscv_add_sub_arbiter: RTL

//   Shares one add/sub datapath among NUM_REQ requesters: ALU ADD/SUB[W], load/store address

---
 rtl/zion_riscv_add_sub_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/zion_riscv_add_sub_arbiter.sv
// rtl/zion_riscv_add_sub_arbiter.sv - round-robin shared add/sub datapath for EX requesters
// One operation issued per cycle into a single registered result slot.
module zion_riscv_add_sub_arbiter #(
  parameter int RV64    = 0,
  parameter int NUM_REQ = 3,
  localparam int CW     = 32 * (RV64 + 1),
  localparam int OPW    = RV64 + 2,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  output logic [NUM_REQ-1:0]     o_req_ready,
  input  logic [NUM_REQ*OPW-1:0] i_req_op,
  input  logic [NUM_REQ-1:0]     i_req_uns,
  input  logic [NUM_REQ*CW-1:0]  i_req_s1,
  input  logic [NUM_REQ*CW-1:0]  i_req_s2,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [IDW-1:0]         o_rsp_id,
  output logic [CW-1:0]          o_rsp_rslt,
  output logic                   o_rsp_lt,
  output logic                   o_rsp_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("zion_riscv_add_sub_arbiter: NUM_REQ must be in 2..8");
  end

  logic [IDW-1:0] rr_q, rr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [CW-1:0]  rsp_rslt_q, rsp_rslt_d;
  logic           rsp_lt_q, rsp_lt_d;
  logic           rsp_err_q, rsp_err_d;

  logic           issue_en;
  logic           gnt_any;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   idx;
  logic           hs;

  // Scan from the rr pointer upward with wrap-around; first valid wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NUM_REQ)) idx = idx - (IDW+1)'(NUM_REQ);
      if (!gnt_any && i_req_valid[idx[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = idx[IDW-1:0];
      end
    end
  end

  assign issue_en = rst_n & (~rsp_valid_q | i_rsp_ready);
  assign hs       = gnt_any & issue_en;

  always_comb begin
    o_req_ready = '0;
    if (hs) o_req_ready[gnt_id] = 1'b1;
  end

  logic [OPW-1:0] op_g;
  logic [CW-1:0]  s1_g, s2_g, s1t, s2t, sum, rslt;
  logic           uns_g, is_add, is_sub, is_w;
  logic           m1, m2, ms, lt;

  always_comb begin
    op_g   = i_req_op[gnt_id*OPW +: OPW];
    s1_g   = i_req_s1[gnt_id*CW +: CW];
    s2_g   = i_req_s2[gnt_id*CW +: CW];
    uns_g  = i_req_uns[gnt_id];
    is_add = op_g[0];
    is_sub = op_g[1];
    is_w   = (RV64 != 0) ? op_g[OPW-1] : 1'b0;
    s1t    = s1_g & {CW{is_add | is_sub}};
    s2t    = is_sub ? ~s2_g : (is_add ? s2_g : '0);
    sum    = s1t + s2t + CW'(is_sub);
    rslt   = sum;
    // .W results sign-extend from bit 31; loop is empty on the 32-bit build.
    if (is_w) begin
      for (int b = 32; b < CW; b++) rslt[b] = sum[31];
    end
    m1 = is_w ? s1_g[31] : s1_g[CW-1];
    m2 = is_w ? s2_g[31] : s2_g[CW-1];
    ms = is_w ? sum[31]  : sum[CW-1];
    lt = (uns_g & (m1 ^ m2)) ? m2 : ms;
  end

  always_comb begin
    rr_d        = rr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_rslt_d  = rsp_rslt_q;
    rsp_lt_d    = rsp_lt_q;
    rsp_err_d   = rsp_err_q;
    if (hs) begin
      rr_d        = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_id;
      rsp_rslt_d  = rslt;
      rsp_lt_d    = lt;
      rsp_err_d   = is_add & is_sub;
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rslt_q  <= '0;
      rsp_lt_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rslt_q  <= rsp_rslt_d;
      rsp_lt_q    <= rsp_lt_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_rslt  = rsp_rslt_q;
  assign o_rsp_lt    = rsp_lt_q;
  assign o_rsp_err   = rsp_err_q;

endmodule
